// File: rtl/instr_word_encoder.sv
// instr_word_encoder: builds 32-bit MIPS words from an instruction kind plus
// operand fields and queues up to two of them, each tagged with its
// instruction-memory byte address. Entry 0 is always the head; a pop shifts
// entry 1 down.
module instr_word_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [15:0] emit_cnt
);

  typedef enum logic [3:0] {
    K_ADD = 4'd0, K_SUB = 4'd1, K_AND = 4'd2, K_OR  = 4'd3,
    K_SLT = 4'd4, K_LW  = 4'd5, K_SW  = 4'd6, K_BEQ = 4'd7,
    K_J   = 4'd8, K_LUI = 4'd9, K_ORI = 4'd10, K_NOP = 4'd11
  } kind_e;

  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [15:0] emit_q, emit_d;

  logic        legal;
  logic        push;
  logic        pop;
  logic        take_illegal;
  logic [31:0] word;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  assign legal     = (in_kind <= K_NOP);
  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = out_valid ? instr0_q : 32'h0;
  assign out_addr  = out_valid ? addr0_q  : 32'h0;
  assign err_illegal = err_q;
  assign emit_cnt  = emit_q;

  assign push         = in_valid && in_ready && legal;
  assign take_illegal = in_valid && in_ready && !legal;
  assign pop          = out_valid && out_ready;

  // Field assembly for the requested kind; unused fields are simply dropped.
  always_comb begin
    word = 32'h0;
    case (in_kind)
      K_ADD: word = r_word(in_rs, in_rt, in_rd, 6'b100000);
      K_SUB: word = r_word(in_rs, in_rt, in_rd, 6'b100010);
      K_AND: word = r_word(in_rs, in_rt, in_rd, 6'b100100);
      K_OR:  word = r_word(in_rs, in_rt, in_rd, 6'b100101);
      K_SLT: word = r_word(in_rs, in_rt, in_rd, 6'b101010);
      K_LW:  word = i_word(6'b100011, in_rs, in_rt, in_imm);
      K_SW:  word = i_word(6'b101011, in_rs, in_rt, in_imm);
      K_BEQ: word = i_word(6'b000100, in_rs, in_rt, in_imm);
      K_J:   word = {6'b000010, in_target};
      K_LUI: word = i_word(6'b001111, 5'd0, in_rt, in_imm);
      K_ORI: word = i_word(6'b001101, in_rs, in_rt, in_imm);
      default: word = 32'h0;
    endcase
  end

  // Buffer, address, counter and sticky-error next state; flush wins over all.
  always_comb begin
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    addr0_d  = addr0_q;
    addr1_d  = addr1_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    err_d    = err_q;
    emit_d   = emit_q;
    if (flush) begin
      cnt_d  = 2'd0;
      addr_d = BASE_ADDR;
      err_d  = 1'b0;
      emit_d = 16'd0;
    end else begin
      if (take_illegal) err_d = 1'b1;
      if (push) addr_d = addr_q + ADDR_STEP;
      if (pop) emit_d = emit_q + 16'd1;
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            instr0_d = word;
            addr0_d  = addr_q;
          end else begin
            instr1_d = word;
            addr1_d  = addr_q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          instr0_d = instr1_q;
          addr0_d  = addr1_q;
          cnt_d    = cnt_q - 2'd1;
        end
        2'b11: begin
          // only reachable at occupancy 1: the new word becomes the head
          instr0_d = word;
          addr0_d  = addr_q;
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr0_q <= 32'h0;
      instr1_q <= 32'h0;
      addr0_q  <= 32'h0;
      addr1_q  <= 32'h0;
      cnt_q    <= 2'd0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
      emit_q   <= 16'd0;
    end else begin
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      emit_q   <= emit_d;
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Bench for instr_word_encoder: directed literal checks followed by random
// traffic compared every cycle against a queue-based reference model.
module tb_instr_word_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_kind = 4'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [15:0] in_imm = 16'd0;
  logic [25:0] in_target = 26'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err_illegal;
  logic [15:0] emit_cnt;

  int n_vec = 0;
  int n_err = 0;

  instr_word_encoder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_illegal(err_illegal), .emit_cnt(emit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding written from the instruction-format tables.
  function automatic logic [31:0] ref_enc(input int kind, input int rs, input int rt,
                                          input int rd, input int imm, input int tgt);
    int functs [5] = '{32, 34, 36, 37, 42};
    int ops    [6] = '{35, 43, 4, 2, 15, 13};
    longint w;
    w = 0;
    if (kind <= 4)       w = (rs << 21) + (rt << 16) + (rd << 11) + functs[kind];
    else if (kind == 8)  w = (2 << 26) + tgt;
    else if (kind == 9)  w = (15 << 26) + (rt << 16) + imm;
    else if (kind <= 10) w = (ops[kind-5] << 26) + (rs << 21) + (rt << 16) + imm;
    return w[31:0];
  endfunction

  // Reference model: a queue of {word, addr} plus address/error/counter.
  logic [63:0] mq[$];
  logic [31:0] maddr = 32'h0;
  logic        merr = 1'b0;
  logic [15:0] memit = 16'd0;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      mq.delete();
      maddr = 32'h0;
      merr  = 1'b0;
      memit = 16'd0;
    end else begin
      bit rdy;
      rdy = (mq.size() < 2);
      if (mq.size() > 0 && out_ready) begin
        void'(mq.pop_front());
        memit = memit + 16'd1;
      end
      if (in_valid && rdy) begin
        if (in_kind < 12) begin
          mq.push_back({ref_enc(in_kind, in_rs, in_rt, in_rd, in_imm, in_target), maddr});
          maddr = maddr + 32'd4;
        end else begin
          merr = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, mq.size() < 2);
      check("out_valid", out_valid, mq.size() > 0);
      check("out_instr", out_instr, mq.size() > 0 ? mq[0][63:32] : 32'h0);
      check("out_addr", out_addr, mq.size() > 0 ? mq[0][31:0] : 32'h0);
      check("err_illegal", err_illegal, merr);
      check("emit_cnt", emit_cnt, memit);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int kind, input int rs, input int rt,
                       input int rd, input int imm, input int tgt);
    in_valid  = v;
    in_kind   = kind[3:0];
    in_rs     = rs[4:0];
    in_rt     = rt[4:0];
    in_rd     = rd[4:0];
    in_imm    = imm[15:0];
    in_target = tgt[25:0];
  endtask

  task automatic do_flush();
    drive(0, 0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    // model encoder pinned against hand-assembled words
    check("mdl_add", ref_enc(0, 1, 2, 3, 0, 0), 32'h0022_1820);
    check("mdl_lui", ref_enc(9, 7, 9, 0, 'h1234, 0), 32'h3C09_1234);
    check("mdl_j", ref_enc(8, 0, 0, 0, 0, 'h10_0000), 32'h0810_0000);

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_emit", emit_cnt, 0);
    #1 rst = 1'b0;
    tick();

    // ADD with out_ready=1
    out_ready = 1'b1;
    drive(1, 0, 1, 2, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("add_word", out_instr, 32'h0022_1820);
    check("add_addr", out_addr, 32'h0);
    tick();
    check("add_emit", emit_cnt, 1);

    // LW then BEQ back to back
    do_flush();
    drive(1, 5, 29, 8, 0, 'h0004, 0);
    tick();
    check("lw_word", out_instr, 32'h8FA8_0004);
    check("lw_addr", out_addr, 32'h0);
    drive(1, 7, 1, 2, 0, 'hFFFF, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("beq_word", out_instr, 32'h1022_FFFF);
    check("beq_addr", out_addr, 32'h4);
    tick();

    // J then LUI (rs forced to zero)
    do_flush();
    drive(1, 8, 0, 0, 0, 0, 'h10_0000);
    tick();
    check("j_word", out_instr, 32'h0810_0000);
    drive(1, 9, 7, 9, 0, 'h1234, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("lui_word", out_instr, 32'h3C09_1234);
    tick();

    // full buffer with stalled consumer
    do_flush();
    out_ready = 1'b0;
    drive(1, 10, 9, 9, 0, 'h5678, 0);
    tick();
    drive(1, 0, 1, 1, 1, 0, 0);
    tick();
    drive(1, 1, 2, 2, 2, 0, 0);
    check("full_ready", in_ready, 0);
    check("full_head", out_instr, 32'h3529_5678);
    tick();
    check("hold_head", out_instr, 32'h3529_5678);
    check("hold_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    check("drain_addr1", out_addr, 32'h4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("drain_addr2", out_addr, 32'h8);
    tick();
    check("drain_empty", out_valid, 0);

    // illegal kind then SUB
    do_flush();
    drive(1, 13, 1, 1, 1, 1, 1);
    tick();
    check("ill_err", err_illegal, 1);
    check("ill_nopush", out_valid, 0);
    drive(1, 1, 4, 5, 6, 0, 0);
    out_ready = 1'b0;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("sub_word", out_instr, 32'h0085_3022);
    check("sub_addr", out_addr, 32'h0);
    check("ill_sticky", err_illegal, 1);
    out_ready = 1'b1;
    tick();

    // async reset with two words buffered
    out_ready = 1'b0;
    drive(1, 0, 1, 2, 3, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 1);
    check("arst_err", err_illegal, 0);
    #1 rst = 1'b0;
    drive(1, 3, 1, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("arst_addr", out_addr, 32'h0);

    // same with flush, plus error cleared
    drive(1, 14, 0, 0, 0, 0, 0);
    tick();
    drive(1, 2, 1, 1, 1, 0, 0);
    tick();
    check("pre_flush_err", err_illegal, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_err", err_illegal, 0);
    check("flush_emit", emit_cnt, 0);
    drive(1, 4, 3, 3, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("flush_addr", out_addr, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom, $urandom,
            $urandom, $urandom, $urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_word_encoder.md
Name: instr_word_encoder

Overview:
Sequential instruction encoder, the inverse of the opcode control decoder. It accepts an instruction kind plus operand fields over a valid/ready handshake and assembles the 32-bit MIPS word. It buffers up to two encoded words, each tagged with its instruction-memory byte address. Testbenches and the program loader use it to write instruction memory, which the fetch/decode path later reads.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address tagged on the first word after reset/flush
ADDR_STEP, 4, address increment per accepted legal instruction

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of buffer, address, counter, error
in_valid  input  1  request valid
in_ready  output  1  encoder can accept this cycle
in_kind  input  4  instruction kind (encoding below)
in_rs  input  5  rs field
in_rt  input  5  rt field
in_rd  input  5  rd field (R-type only)
in_imm  input  16  immediate (I-type only)
in_target  input  26  jump target (J only)
out_valid  output  1  buffer head valid
out_ready  input  1  consumer takes head
out_instr  output  32  encoded word at head
out_addr  output  32  byte address of head word
err_illegal  output  1  sticky: illegal kind was accepted
emit_cnt  output  16  words popped since reset/flush, wraps at 16'hFFFF->0

Behaviour:
- Kind encoding: 0 ADD (funct 6'b100000), 1 SUB (100010), 2 AND (100100), 3 OR (100101), 4 SLT (101010), 5 LW (op 100011), 6 SW (101011), 7 BEQ (000100), 8 J (000010), 9 LUI (001111), 10 ORI (001101), 11 NOP (32'h0), 12-15 illegal.
- R-type word: {6'b0, rs, rt, rd, 5'b0, funct}.
- I-type word: {op, rs, rt, imm}. LUI forces rs=0. J word: {6'b000010, target}.
- Unused input fields are ignored.
- Buffer: 2-entry FIFO of {instr, addr}. in_ready = (occupancy < 2); it does not depend on out_ready, so there is no pass-through when full.
- Push: in_valid && in_ready && legal kind. Word and current address are written; address register += ADDR_STEP (32-bit wrap).
- Illegal kind with in_valid && in_ready: input consumed, nothing pushed, address unchanged, err_illegal set to 1 at that edge.
- Latency: word accepted at edge N gives out_valid=1 from edge N onward when the buffer was empty.
- Pop: out_valid && out_ready. Head advances and emit_cnt increments.
- Simultaneous push and pop at occupancy 1: occupancy stays 1, order preserved.
- Push while occupancy 2 is impossible, because in_ready=0.
- out_instr/out_addr hold stable while out_valid && !out_ready.
- When out_valid=0, out_instr and out_addr read 0.
- flush (sync, highest priority): occupancy 0, address = BASE_ADDR, emit_cnt = 0, err_illegal = 0. Push and pop in that cycle are discarded.
- rst (async, any time including mid-transfer): in_ready=1, out_valid=0, out_instr=0, out_addr=0, err_illegal=0, emit_cnt=0, address=BASE_ADDR, occupancy 0.

Test Plan:
- ADD rs=1 rt=2 rd=3 with out_ready=1 -> out_instr=32'h0022_1820, out_addr=0x0 one edge after accept; emit_cnt=1 after pop.
- Back-to-back LW rs=29 rt=8 imm=0x0004, then BEQ rs=1 rt=2 imm=0xFFFF -> 32'h8FA8_0004 @0x0, then 32'h1022_FFFF @0x4.
- J target=26'h010_0000, then LUI rs=7 rt=9 imm=0x1234 -> 32'h0810_0000, then 32'h3C09_1234 (rs forced 0).
- out_ready=0, push ORI rs=9 rt=9 imm=0x5678 plus two more -> in_ready drops after 2 accepts, head holds 32'h3529_5678. Release out_ready -> words drain in order with addresses 0x0, 0x4, 0x8.
- Kind 13 accepted, then SUB rs=4 rt=5 rd=6 -> err_illegal=1 stays set; the only word out is 32'h0085_3022 @0x0.
- Two words buffered, then assert rst asynchronously between edges -> out_valid=0 immediately. Next push is tagged BASE_ADDR. Repeat with flush -> same result at the next edge, err_illegal=0.
